// File: rtl/vgachargen_mem_ctrl_pkg.sv
// vgachargen_mem_ctrl_pkg: shared sizes, region/state enums and glyph-row merge helper for the text-mode memory controller
package vgachargen_mem_ctrl_pkg;
  localparam int MAP_DEPTH    = 2400;
  localparam int GLYPH_COUNT  = 128;
  localparam int ADDR_W       = 14;
  localparam int MAP_ADDR_W   = 12;
  localparam int GLYPH_ADDR_W = $clog2(GLYPH_COUNT);
  localparam logic [MAP_ADDR_W-1:0] MAP_END     = MAP_ADDR_W'(MAP_DEPTH);
  localparam logic [MAP_ADDR_W-1:0] MAP_LAST    = MAP_ADDR_W'(MAP_DEPTH - 1);
  localparam logic [MAP_ADDR_W-1:0] CTRL_CLEAR  = 12'd0;
  localparam logic [MAP_ADDR_W-1:0] CTRL_STATUS = 12'd1;
  typedef enum logic [1:0] {REG_CH = 2'b00, REG_COL = 2'b01, REG_GLYPH = 2'b10, REG_CTRL = 2'b11} region_e;
  typedef enum logic [2:0] {IDLE, MAP_ACC, MAP_RD, GL_RD, GL_WR, RESP, CLEAR} ctrl_state_e;
  function automatic logic [127:0] put_quarter(logic [127:0] row, logic [1:0] q, logic [31:0] w);
    logic [127:0] r;
    r = row;
    r[{q, 5'b0} +: 32] = w;
    return r;
  endfunction
endpackage

// File: rtl/vgachargen_mem_ctrl_if.sv
// vgachargen_mem_ctrl_if: host request/response bus (req/we/addr/wdata in, ready/rdata/err out)
interface vgachargen_mem_ctrl_if;
  import vgachargen_mem_ctrl_pkg::*;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic [31:0]       rdata;
  logic              err;
  modport master (output req, we, addr, wdata, input ready, rdata, err);
  modport slave (input req, we, addr, wdata, output ready, rdata, err);
endinterface

// File: rtl/vgachargen_fill_engine.sv
// vgachargen_fill_engine: map index sweep 0..MAP_DEPTH-1, one index per cycle after start_i
// Ports: clk_i, arstn_i (async active-low), start_i (pulse), busy_o (high MAP_DEPTH cycles), idx_o (current index)
// Only compiled when VGACHARGEN_CLEAR_EN is defined.
`ifdef VGACHARGEN_CLEAR_EN
module vgachargen_fill_engine
  import vgachargen_mem_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic [MAP_ADDR_W-1:0] idx_o
);
  logic                  busy_q, busy_d, last;
  logic [MAP_ADDR_W-1:0] idx_q, idx_d;
  assign last   = busy_q && idx_q == MAP_LAST;
  assign busy_o = busy_q;
  assign idx_o  = idx_q;
  always_comb begin
    busy_d = start_i || (busy_q && !last);
    idx_d  = start_i ? '0 : busy_q ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
    end
  end
endmodule
`endif

// File: rtl/vgachargen_mem_ctrl.sv
// vgachargen_mem_ctrl: sequences host accesses onto port A of char map, colour map and RW glyph table
// Ports: clk_i, arstn_i (async active-low); bus (slave: req/we/addr/wdata -> ready/rdata/err);
//   ch_map_*/col_map_* (12-bit addr, wen, 8-bit data out/in), ch_t_rw_* (7-bit row addr, wen, 128-bit data out/in).
// Memories have 1-cycle read latency; glyph writes are read-modify-write of one 32-bit quarter.
// Define VGACHARGEN_CLEAR_EN to enable the CLEAR command and map fill engine.
module vgachargen_mem_ctrl
  import vgachargen_mem_ctrl_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    arstn_i,
  vgachargen_mem_ctrl_if.slave    bus,
  output logic [MAP_ADDR_W-1:0]   ch_map_addr_o,
  output logic                    ch_map_wen_o,
  output logic [7:0]              ch_map_data_o,
  input  logic [7:0]              ch_map_data_i,
  output logic [MAP_ADDR_W-1:0]   col_map_addr_o,
  output logic                    col_map_wen_o,
  output logic [7:0]              col_map_data_o,
  input  logic [7:0]              col_map_data_i,
  output logic [GLYPH_ADDR_W-1:0] ch_t_rw_addr_o,
  output logic                    ch_t_rw_wen_o,
  output logic [127:0]            ch_t_rw_data_o,
  input  logic [127:0]            ch_t_rw_data_i
);
  ctrl_state_e       state_q, state_d;
  logic              we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [127:0]      row_q, row_d;
  region_e           req_reg, cur_reg;
  assign req_reg = region_e'(bus.addr[13:12]);
  assign cur_reg = region_e'(addr_q[13:12]);
`ifdef VGACHARGEN_CLEAR_EN
  logic                  clr_q, clr_d, stat_q, stat_d, fill_start, busy, ctrl_ok;
  logic [MAP_ADDR_W-1:0] fill_idx;
  vgachargen_fill_engine u_fill (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .start_i (fill_start),
    .busy_o  (busy),
    .idx_o   (fill_idx)
  );
  // only STATUS reads and (rejected) CLEAR writes are answered while the fill runs
  assign ctrl_ok = bus.req && req_reg == REG_CTRL &&
                   ((bus.addr[11:0] == CTRL_STATUS && !bus.we) || (bus.addr[11:0] == CTRL_CLEAR && bus.we));
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      clr_q  <= 1'b0;
      stat_q <= 1'b0;
    end else begin
      clr_q  <= clr_d;
      stat_q <= stat_d;
    end
  end
`endif
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    row_d   = row_q;
    ch_map_addr_o  = '0;
    ch_map_wen_o   = 1'b0;
    ch_map_data_o  = '0;
    col_map_addr_o = '0;
    col_map_wen_o  = 1'b0;
    col_map_data_o = '0;
    ch_t_rw_addr_o = '0;
    ch_t_rw_wen_o  = 1'b0;
    ch_t_rw_data_o = '0;
    bus.ready = 1'b0;
    bus.rdata = '0;
    bus.err   = 1'b0;
`ifdef VGACHARGEN_CLEAR_EN
    clr_d      = clr_q;
    stat_d     = 1'b0;
    fill_start = 1'b0;
`endif
    case (state_q)
      IDLE: if (bus.req) begin
        we_d    = bus.we;
        addr_d  = bus.addr;
        wdata_d = bus.wdata;
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = RESP;
`ifdef VGACHARGEN_CLEAR_EN
        clr_d = 1'b0;
`endif
        // err_d starts set; each legal decode clears it and picks the access path
        case (req_reg)
          REG_CH, REG_COL: if (bus.addr[11:0] < MAP_END) begin
            err_d   = 1'b0;
            state_d = MAP_ACC;
          end
          REG_GLYPH: if (bus.addr[11:9] == 3'b0) begin
            err_d   = 1'b0;
            state_d = GL_RD;
          end
          default: begin
            if (bus.addr[11:0] == CTRL_STATUS && !bus.we) err_d = 1'b0;
`ifdef VGACHARGEN_CLEAR_EN
            if (bus.addr[11:0] == CTRL_CLEAR && bus.we) begin
              err_d = 1'b0;
              clr_d = 1'b1;
            end
`endif
          end
        endcase
      end
      MAP_ACC: begin
        ch_map_addr_o  = cur_reg == REG_CH ? addr_q[11:0] : '0;
        ch_map_wen_o   = cur_reg == REG_CH && we_q;
        ch_map_data_o  = cur_reg == REG_CH ? wdata_q[7:0] : '0;
        col_map_addr_o = cur_reg == REG_COL ? addr_q[11:0] : '0;
        col_map_wen_o  = cur_reg == REG_COL && we_q;
        col_map_data_o = cur_reg == REG_COL ? wdata_q[7:0] : '0;
        state_d = we_q ? RESP : MAP_RD;
      end
      GL_RD: begin
        ch_t_rw_addr_o = addr_q[8:2];
        state_d = MAP_RD;
      end
      // shared read-capture cycle: map reads, glyph reads and the read half of glyph RMW
      MAP_RD: begin
        row_d   = ch_t_rw_data_i;
        rdata_d = cur_reg == REG_GLYPH ? ch_t_rw_data_i[{addr_q[1:0], 5'b0} +: 32]
                                       : {24'b0, cur_reg == REG_CH ? ch_map_data_i : col_map_data_i};
        state_d = cur_reg == REG_GLYPH && we_q ? GL_WR : RESP;
      end
      GL_WR: begin
        ch_t_rw_addr_o = addr_q[8:2];
        ch_t_rw_wen_o  = 1'b1;
        ch_t_rw_data_o = put_quarter(row_q, addr_q[1:0], wdata_q);
        rdata_d = '0;
        state_d = RESP;
      end
      RESP: begin
        bus.ready = 1'b1;
        bus.rdata = rdata_q;
        bus.err   = err_q;
        state_d   = IDLE;
`ifdef VGACHARGEN_CLEAR_EN
        if (clr_q) begin
          state_d    = CLEAR;
          fill_start = 1'b1;
          clr_d      = 1'b0;
        end
`endif
      end
`ifdef VGACHARGEN_CLEAR_EN
      CLEAR: begin
        ch_map_addr_o  = fill_idx;
        ch_map_wen_o   = busy;
        ch_map_data_o  = wdata_q[7:0];
        col_map_addr_o = fill_idx;
        col_map_wen_o  = busy;
        col_map_data_o = wdata_q[15:8];
        bus.ready = stat_q;
        bus.rdata = stat_q ? rdata_q : '0;
        bus.err   = stat_q && err_q;
        // stat_q blocks re-accepting the same held request in its ready cycle
        if (ctrl_ok && busy && !stat_q) begin
          stat_d  = 1'b1;
          rdata_d = {31'b0, !bus.we};
          err_d   = bus.we;
        end
        if (!busy && !stat_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      row_q   <= row_d;
    end
  end
  a_req_held: assert property (@(posedge clk_i) disable iff (!arstn_i)
    (state_q inside {MAP_ACC, MAP_RD, GL_RD, GL_WR, RESP}) |-> bus.req);
endmodule

// File: tb/tb_vgachargen_mem_ctrl.sv
// tb_vgachargen_mem_ctrl: directed stimulus with response scoreboard and port-A memory models
module tb_vgachargen_mem_ctrl;
  import vgachargen_mem_ctrl_pkg::*;
  localparam logic [127:0] ROW3 = {32'hFFFFFFFF, 32'h00FF00FF, 64'hFFFFFFFF_FFFFFFFF};
  typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;
  vgachargen_mem_ctrl_if bus();
  logic [11:0]  ch_addr, col_addr;
  logic         ch_wen, col_wen, gl_wen;
  logic [7:0]   ch_do, ch_di, col_do, col_di;
  logic [6:0]   gl_addr;
  logic [127:0] gl_do, gl_di;
  vgachargen_mem_ctrl dut (
    .clk_i(clk), .arstn_i(arstn), .bus(bus),
    .ch_map_addr_o(ch_addr), .ch_map_wen_o(ch_wen), .ch_map_data_o(ch_do), .ch_map_data_i(ch_di),
    .col_map_addr_o(col_addr), .col_map_wen_o(col_wen), .col_map_data_o(col_do), .col_map_data_i(col_di),
    .ch_t_rw_addr_o(gl_addr), .ch_t_rw_wen_o(gl_wen), .ch_t_rw_data_o(gl_do), .ch_t_rw_data_i(gl_di)
  );
  logic [7:0]   ch_mem  [4096];
  logic [7:0]   col_mem [4096];
  logic [127:0] gl_mem  [128];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) begin
        ch_mem[i]  <= 8'h00;
        col_mem[i] <= 8'h00;
      end
      for (int i = 0; i < 128; i++) gl_mem[i] <= (i == 3) ? '1 : '0;
    end else begin
      if (ch_wen) ch_mem[ch_addr] <= ch_do;
      if (col_wen) col_mem[col_addr] <= col_do;
      if (gl_wen) gl_mem[gl_addr] <= gl_do;
    end
    ch_di  <= ch_mem[ch_addr];
    col_di <= col_mem[col_addr];
    gl_di  <= gl_mem[gl_addr];
  end
  int cyc = 0, errors = 0, checks = 0;
  int ch_wen_n = 0, col_wen_n = 0, gl_wen_n = 0, ch_wen_cyc = -1;
  logic [11:0] ch_wen_addr = '0;
  exp_t sb[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ch_wen) begin
      ch_wen_n++;
      ch_wen_cyc  = cyc;
      ch_wen_addr = ch_addr;
    end
    if (col_wen) col_wen_n++;
    if (gl_wen) gl_wen_n++;
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got rdata=%0h err=%0b expected no response", bus.rdata, bus.err);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", 128'(bus.rdata), 128'(e.rdata));
        check("resp_err", 128'(bus.err), 128'(e.err));
        if (e.cyc >= 0) check("resp_latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end
  task automatic idle();
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask
  // called at a negedge; returns at the negedge after ready with req still high
  task automatic issue(input logic we, input logic [13:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat, output int at);
    exp_t e;
    bit seen;
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wd;
    at      = cyc;
    e.rdata = er;
    e.err   = ee;
    e.cyc   = lat > 0 ? cyc + lat : -1;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ready;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready expected ready for addr %0h", addr);
    end
    @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int t, n_ch, n_col, n_gl, bad;
    idle();
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(bus.ready), 0);
    check("rst_rdata_err", 128'({bus.rdata, bus.err}), 0);
    check("rst_wen", 128'({ch_wen, col_wen, gl_wen}), 0);
    check("rst_addr", 128'({ch_addr, col_addr, gl_addr}), 0);
    mem_init = 1'b0;
    arstn = 1'b1;
    @(negedge clk);
    // char map write then read back
    issue(1'b1, 14'h0005, 32'h41, 32'h0, 1'b0, 2, t);
    check("ch_wen_cycle", 128'(ch_wen_cyc), 128'(t + 1));
    check("ch_wen_addr", 128'(ch_wen_addr), 128'd5);
    check("ch_mem5", 128'(ch_mem[5]), 128'h41);
    issue(1'b0, 14'h0005, 32'h0, 32'h41, 1'b0, 3, t);
    // glyph RMW into quarter 2 of row 3
    issue(1'b1, 14'h200E, 32'h00FF00FF, 32'h0, 1'b0, 4, t);
    check("glyph_row3", gl_mem[3], ROW3);
    issue(1'b0, 14'h200E, 32'h0, 32'h00FF00FF, 1'b0, 3, t);
    issue(1'b0, 14'h200F, 32'h0, 32'hFFFFFFFF, 1'b0, 3, t);
    // error decodes: no memory writes
    n_ch = ch_wen_n; n_col = col_wen_n; n_gl = gl_wen_n;
    issue(1'b0, 14'h1960, 32'h0, 32'h0, 1'b1, 1, t);
    issue(1'b1, 14'h0960, 32'h99, 32'h0, 1'b1, 1, t);
    issue(1'b1, 14'h2200, 32'h12345678, 32'h0, 1'b1, 1, t);
    issue(1'b0, 14'h3005, 32'h0, 32'h0, 1'b1, 1, t);
    issue(1'b0, 14'h3001, 32'h0, 32'h0, 1'b0, 1, t);
    check("err_no_wen", 128'((ch_wen_n - n_ch) + (col_wen_n - n_col) + (gl_wen_n - n_gl)), 0);
    check("ch_mem_idx_oob", 128'(ch_mem[2400]), 0);
    // last valid map index
    issue(1'b1, 14'h195F, 32'h3C, 32'h0, 1'b0, 2, t);
    issue(1'b0, 14'h195F, 32'h0, 32'h3C, 1'b0, 3, t);
    check("col_mem2399", 128'(col_mem[2399]), 128'h3C);
`ifdef VGACHARGEN_CLEAR_EN
    n_ch = ch_wen_n; n_col = col_wen_n;
    issue(1'b1, 14'h3000, 32'h1F20, 32'h0, 1'b0, 1, t);
    issue(1'b0, 14'h3001, 32'h0, 32'h1, 1'b0, 1, t);
    issue(1'b1, 14'h3000, 32'h0505, 32'h0, 1'b1, 1, t);
    issue(1'b1, 14'h0007, 32'h55, 32'h0, 1'b0, 0, t);
    issue(1'b0, 14'h3001, 32'h0, 32'h0, 1'b0, 1, t);
    check("clear_ch_wen", 128'(ch_wen_n - n_ch), 128'd2401);
    check("clear_col_wen", 128'(col_wen_n - n_col), 128'd2400);
    bad = 0;
    for (int i = 0; i < MAP_DEPTH; i++) begin
      if (ch_mem[i] !== ((i == 7) ? 8'h55 : 8'h20)) bad++;
      if (col_mem[i] !== 8'h1F) bad++;
    end
    check("clear_fill", 128'(bad), 0);
`else
    n_ch = ch_wen_n; n_col = col_wen_n;
    issue(1'b1, 14'h3000, 32'h1F20, 32'h0, 1'b1, 1, t);
    check("clear_disabled_no_wen", 128'((ch_wen_n - n_ch) + (col_wen_n - n_col)), 0);
    check("clear_disabled_ch0", 128'(ch_mem[0]), 0);
    issue(1'b1, 14'h000A, 32'hAA, 32'h0, 1'b0, 2, t);
    issue(1'b1, 14'h100B, 32'hBB, 32'h0, 1'b0, 2, t);
    issue(1'b0, 14'h000A, 32'h0, 32'hAA, 1'b0, 3, t);
    issue(1'b0, 14'h100B, 32'h0, 32'hBB, 1'b0, 3, t);
    check("b2b_ch10", 128'(ch_mem[10]), 128'hAA);
    check("b2b_col11", 128'(col_mem[11]), 128'hBB);
`endif
    // reset in the middle of a glyph RMW
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 14'h200C;
    bus.wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("glrd_addr", 128'(gl_addr), 128'd3);
    arstn = 1'b0;
    #1;
    check("midrst_ready", 128'(bus.ready), 0);
    check("midrst_outs", 128'({gl_wen, gl_addr, ch_wen, col_wen}), 0);
    idle();
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    check("midrst_row3", gl_mem[3], ROW3);
    issue(1'b0, 14'h200C, 32'h0, 32'hFFFFFFFF, 1'b0, 3, t);
    issue(1'b1, 14'h0001, 32'h77, 32'h0, 1'b0, 2, t);
    check("post_rst_ch1", 128'(ch_mem[1]), 128'h77);
    idle();
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 128'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
